seg_scan_decoder: RTL and testbench

- Receive-side counterpart of the seven-segment encoder: samples a multiplexed seven-segment display bus (segment lines plus one-hot digit select) and recovers the hex nibble driven on each digit.
- Used as an on-chip readback/monitor of the board display path, so the CPU or a bench can check what the display actually shows.
- Captures a pattern only after it has been stable; flags blank and illegal patterns; reports per-digit status and frame completion.

---
 rtl/seg_scan_decoder_pkg.sv | 28 ++
 rtl/seg_scan_decoder_pattern_decode.sv | 38 +++
 rtl/seg_scan_decoder.sv | 170 +++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_decoder_pkg.sv
// Shared definitions for the seven-segment scan decoder: segment patterns in
// Seg[6:0] = {g,f,e,d,c,b,a} order and an index-width helper.
package seg_scan_decoder_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h67;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // A single-digit display still needs a 1-bit index port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_scan_decoder_pattern_decode.sv
// Combinational inverse of the seven-segment encoder table: pattern to nibble,
// with legal and blank indications.
module seg_pattern_decode
  import seg_scan_decoder_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_nib,
  output logic       o_legal,
  output logic       o_blank
);

  always_comb begin
    o_nib   = 4'h0;
    o_legal = 1'b1;
    case (i_seg)
      SEG_0:   o_nib = 4'h0;
      SEG_1:   o_nib = 4'h1;
      SEG_2:   o_nib = 4'h2;
      SEG_3:   o_nib = 4'h3;
      SEG_4:   o_nib = 4'h4;
      SEG_5:   o_nib = 4'h5;
      SEG_6:   o_nib = 4'h6;
      SEG_7:   o_nib = 4'h7;
      SEG_8:   o_nib = 4'h8;
      SEG_9:   o_nib = 4'h9;
      SEG_A:   o_nib = 4'hA;
      SEG_B:   o_nib = 4'hB;
      SEG_C:   o_nib = 4'hC;
      SEG_D:   o_nib = 4'hD;
      SEG_E:   o_nib = 4'hE;
      SEG_F:   o_nib = 4'hF;
      default: o_legal = 1'b0;
    endcase
  end

  assign o_blank = (i_seg == SEG_BLANK);

endmodule

// File: rtl/seg_scan_decoder.sv
// Monitors a multiplexed seven-segment bus: synchronises it, waits for a stable
// pattern, then records the decoded nibble and status for the selected digit.
module seg_scan_decoder
  import seg_scan_decoder_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [6:0]                   Seg,
  input  logic [NUM_DIGITS-1:0]        Anode,
  input  logic                         Clear,
  output logic [4*NUM_DIGITS-1:0]      Digits,
  output logic [NUM_DIGITS-1:0]        Valid,
  output logic [NUM_DIGITS-1:0]        Blank,
  output logic [NUM_DIGITS-1:0]        Invalid,
  output logic                         Update,
  output logic [idx_w(NUM_DIGITS)-1:0] UpdIdx,
  output logic                         Conflict,
  output logic                         FrameDone
);

  localparam int            IW      = idx_w(NUM_DIGITS);
  localparam int            CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [6:0]              r_seg_sync [SYNC_STAGES];
  logic [NUM_DIGITS-1:0]   r_an_sync  [SYNC_STAGES];
  logic [6:0]              r_seg_prev;
  logic [NUM_DIGITS-1:0]   r_an_prev;
  logic [CW-1:0]           r_cnt;
  logic                    r_evt;
  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [NUM_DIGITS-1:0]   r_valid, r_blank, r_invalid, r_seen;
  logic                    r_update, r_conflict, r_frame;
  logic [IW-1:0]           r_upd_idx;

  logic [6:0]              w_seg_s;
  logic [NUM_DIGITS-1:0]   w_an_s;
  logic                    w_change;
  logic [CW-1:0]           w_cnt_nxt;
  logic                    w_evt_nxt;
  logic [3:0]              w_nib;
  logic                    w_legal, w_blank, w_onehot, w_full;
  logic [IW-1:0]           w_idx;
  logic [NUM_DIGITS-1:0]   w_seen_nxt;

  // ---- stage: input synchroniser and stability window ----
  assign w_seg_s   = r_seg_sync[SYNC_STAGES-1];
  assign w_an_s    = r_an_sync[SYNC_STAGES-1];
  assign w_change  = (w_seg_s != r_seg_prev) || (w_an_s != r_an_prev);
  assign w_cnt_nxt = w_change ? CW'(1) : ((r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + CW'(1));
  // A change that lands directly on the limit (STABLE_CYCLES=1) still fires.
  assign w_evt_nxt = (w_cnt_nxt == CNT_MAX) && ((r_cnt != CNT_MAX) || w_change);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        r_seg_sync[k] <= '0;
        r_an_sync[k]  <= '0;
      end
      r_seg_prev <= '0;
      r_an_prev  <= '0;
      r_cnt      <= '0;
      r_evt      <= 1'b0;
    end else if (Clear) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        r_seg_sync[k] <= '0;
        r_an_sync[k]  <= '0;
      end
      r_seg_prev <= '0;
      r_an_prev  <= '0;
      r_cnt      <= '0;
      r_evt      <= 1'b0;
    end else begin
      r_seg_sync[0] <= Seg;
      r_an_sync[0]  <= Anode;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_seg_sync[k] <= r_seg_sync[k-1];
        r_an_sync[k]  <= r_an_sync[k-1];
      end
      r_seg_prev <= w_seg_s;
      r_an_prev  <= w_an_s;
      r_cnt      <= w_cnt_nxt;
      r_evt      <= w_evt_nxt;
    end
  end

  // ---- stage: decode and capture of the stable sample ----
  seg_pattern_decode u_decode (
    .i_seg   (r_seg_prev),
    .o_nib   (w_nib),
    .o_legal (w_legal),
    .o_blank (w_blank)
  );

  assign w_onehot   = (r_an_prev != '0) &&
                      ((r_an_prev & (r_an_prev - NUM_DIGITS'(1))) == '0);
  assign w_seen_nxt = r_seen | r_an_prev;
  assign w_full     = &w_seen_nxt;

  always_comb begin
    w_idx = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_an_prev[k]) w_idx = IW'(k);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digits   <= '0;
      r_valid    <= '0;
      r_blank    <= '0;
      r_invalid  <= '0;
      r_seen     <= '0;
      r_update   <= 1'b0;
      r_upd_idx  <= '0;
      r_conflict <= 1'b0;
      r_frame    <= 1'b0;
    end else if (Clear) begin
      r_digits   <= '0;
      r_valid    <= '0;
      r_blank    <= '0;
      r_invalid  <= '0;
      r_seen     <= '0;
      r_update   <= 1'b0;
      r_upd_idx  <= '0;
      r_conflict <= 1'b0;
      r_frame    <= 1'b0;
    end else begin
      r_update   <= 1'b0;
      r_conflict <= 1'b0;
      r_frame    <= 1'b0;
      if (r_evt && w_onehot) begin
        r_update  <= 1'b1;
        r_upd_idx <= w_idx;
        if (w_legal) begin
          r_digits[{w_idx, 2'b00} +: 4] <= w_nib;
          r_valid[w_idx]   <= 1'b1;
          r_blank[w_idx]   <= 1'b0;
          r_invalid[w_idx] <= 1'b0;
        end else begin
          r_valid[w_idx]   <= 1'b0;
          r_blank[w_idx]   <= w_blank;
          r_invalid[w_idx] <= !w_blank;
        end
        if (w_full) begin
          r_frame <= 1'b1;
          r_seen  <= '0;
        end else begin
          r_seen  <= w_seen_nxt;
        end
      end else if (r_evt && (r_an_prev != '0)) begin
        r_conflict <= 1'b1;
      end
    end
  end

  assign Digits    = r_digits;
  assign Valid     = r_valid;
  assign Blank     = r_blank;
  assign Invalid   = r_invalid;
  assign Update    = r_update;
  assign UpdIdx    = r_upd_idx;
  assign Conflict  = r_conflict;
  assign FrameDone = r_frame;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: vector table plus hand sequences, with a queue of
// expected captures compared whenever the decoder reports an Update.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  Seg = '0;
  logic [3:0]  Anode = '0;
  logic        Clear = 1'b0;
  logic [15:0] Digits;
  logic [3:0]  Valid, Blank, Invalid;
  logic        Update;
  logic [1:0]  UpdIdx;
  logic        Conflict, FrameDone;

  seg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .Seg(Seg), .Anode(Anode), .Clear(Clear),
    .Digits(Digits), .Valid(Valid), .Blank(Blank), .Invalid(Invalid),
    .Update(Update), .UpdIdx(UpdIdx), .Conflict(Conflict), .FrameDone(FrameDone)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  idx;
    logic [15:0] dig;
    logic [3:0]  val, blk, inv;
    logic        frm;
    logic        lat;
  } exp_t;

  typedef struct {
    logic [3:0]  an;
    logic [6:0]  seg;
    int          hold;
    logic        upd;
    logic [1:0]  idx;
    logic [15:0] dig;
    logic [3:0]  val, blk, inv;
    logic        frm;
    int          conf;
    logic        lat;
  } vec_t;

  exp_t exp_q[$];
  vec_t vt[12];
  int   n_chk = 0, n_pass = 0;
  int   cyc = 0, t_first = 0, n_conf = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  task automatic push_exp(input logic [1:0] idx, input logic [15:0] dig, input logic [3:0] val,
                          input logic [3:0] blk, input logic [3:0] inv, input logic frm,
                          input logic lat);
    exp_t e;
    e.idx = idx; e.dig = dig; e.val = val; e.blk = blk; e.inv = inv; e.frm = frm; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_digits"}, Digits, 0);
    check({tag, "_valid"}, Valid, 0);
    check({tag, "_blank"}, Blank, 0);
    check({tag, "_invalid"}, Invalid, 0);
    check({tag, "_update"}, Update, 0);
    check({tag, "_conflict"}, Conflict, 0);
    check({tag, "_frame"}, FrameDone, 0);
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n && Update) begin
      if (exp_q.size() == 0) begin
        check("unexpected_update", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("upd_idx", UpdIdx, e.idx);
        check("digits", Digits, e.dig);
        check("valid", Valid, e.val);
        check("blank", Blank, e.blk);
        check("invalid", Invalid, e.inv);
        check("frame_done", FrameDone, e.frm);
        if (e.lat) check("latency", cyc - t_first, 6);
      end
    end
    if (rst_n && FrameDone && !Update) check("frame_without_update", 1, 0);
    if (rst_n && Conflict) n_conf++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int conf0;
    vt[0]  = '{4'b0001, 7'h3F, 10, 1'b1, 2'd0, 16'h0000, 4'b0001, 4'b0000, 4'b0000, 1'b0, 0, 1'b1};
    vt[1]  = '{4'b0001, 7'h06,  8, 1'b1, 2'd0, 16'h0001, 4'b0001, 4'b0000, 4'b0000, 1'b0, 0, 1'b0};
    vt[2]  = '{4'b0010, 7'h5B,  8, 1'b1, 2'd1, 16'h0021, 4'b0011, 4'b0000, 4'b0000, 1'b0, 0, 1'b0};
    vt[3]  = '{4'b0100, 7'h77,  8, 1'b1, 2'd2, 16'h0A21, 4'b0111, 4'b0000, 4'b0000, 1'b0, 0, 1'b0};
    vt[4]  = '{4'b1000, 7'h71,  8, 1'b1, 2'd3, 16'hFA21, 4'b1111, 4'b0000, 4'b0000, 1'b1, 0, 1'b0};
    vt[5]  = '{4'b0100, 7'h00,  8, 1'b1, 2'd2, 16'hFA21, 4'b1011, 4'b0100, 4'b0000, 1'b0, 0, 1'b0};
    vt[6]  = '{4'b0100, 7'h40,  8, 1'b1, 2'd2, 16'hFA21, 4'b1011, 4'b0000, 4'b0100, 1'b0, 0, 1'b0};
    vt[7]  = '{4'b0011, 7'h3F,  8, 1'b0, 2'd0, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1, 1'b0};
    vt[8]  = '{4'b0000, 7'h7F,  8, 1'b0, 2'd0, 16'h0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 1'b0};
    vt[9]  = '{4'b0001, 7'h7C,  8, 1'b1, 2'd0, 16'hFA2B, 4'b1011, 4'b0000, 4'b0100, 1'b0, 0, 1'b0};
    vt[10] = '{4'b0010, 7'h79,  8, 1'b1, 2'd1, 16'hFAEB, 4'b1011, 4'b0000, 4'b0100, 1'b0, 0, 1'b0};
    vt[11] = '{4'b1000, 7'h4F,  8, 1'b1, 2'd3, 16'h3AEB, 4'b1011, 4'b0000, 4'b0100, 1'b1, 0, 1'b0};

    repeat (3) @(negedge clk);
    check_zero("in_reset");
    rst_n = 1'b1;
    @(negedge clk); #1;
    check_zero("after_reset");

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (vt[i].upd)
        push_exp(vt[i].idx, vt[i].dig, vt[i].val, vt[i].blk, vt[i].inv, vt[i].frm, vt[i].lat);
      conf0   = n_conf;
      Anode   = vt[i].an;
      Seg     = vt[i].seg;
      t_first = cyc + 1;
      repeat (vt[i].hold) @(posedge clk);
      @(negedge clk); #1;
      check($sformatf("vec%0d_conflicts", i), n_conf - conf0, vt[i].conf);
      check($sformatf("vec%0d_pending", i), exp_q.size(), 0);
    end

    // Segment lines bouncing faster than the stability window, then settling on "2".
    conf0 = n_conf;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      Anode = 4'b0010;
      Seg   = (i % 2 == 0) ? 7'h06 : 7'h5B;
      repeat (2) @(posedge clk);
    end
    push_exp(2'd1, 16'h3A2B, 4'b1011, 4'b0000, 4'b0100, 1'b0, 1'b0);
    repeat (16) @(posedge clk);
    @(negedge clk); #1;
    check("toggle_pending", exp_q.size(), 0);
    check("toggle_conflicts", n_conf - conf0, 0);

    // Clear lands on the very edge that would have captured.
    @(negedge clk);
    Anode = 4'b0001;
    Seg   = 7'h3F;
    repeat (6) @(posedge clk);
    @(negedge clk);
    Clear = 1'b1;
    @(negedge clk); #1;
    check_zero("clear");
    Clear = 1'b0;
    push_exp(2'd0, 16'h0000, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b1);
    t_first = cyc + 1;
    repeat (10) @(posedge clk);
    @(negedge clk); #1;
    check("clear_recapture_pending", exp_q.size(), 0);

    // Asynchronous reset in the middle of a stability window.
    @(negedge clk);
    Anode = 4'b0010;
    Seg   = 7'h66;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(2'd1, 16'h0040, 4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b1);
    t_first = cyc + 1;
    repeat (10) @(posedge clk);
    @(negedge clk); #1;
    check("reset_recapture_pending", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
